// File: rtl/bmp_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : bmp_pkg
//  Description : Shared constants, header offsets and FSM state type for the
//                BMP loader with channel masking and its ROM/RAM models.
//  Revision    : 1.0 - initial release
// ============================================================================
package bmp_pkg;

  // ROM/RAM geometry shared with the memory models
  localparam int BYTE_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 20;

  // BMP header byte offsets
  localparam int SIG0     = 0;
  localparam int SIG1     = 1;
  localparam int OFF_LO   = 10;
  localparam int W_LO     = 18;
  localparam int H_LO     = 22;
  localparam int BPP_LO   = 28;
  localparam int HDR_SIZE = 54;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when addr falls inside the 4-byte little-endian field starting at lo
  function automatic logic field_hit(input logic [31:0] addr, input logic [31:0] lo);
    return (addr >= lo) && (addr < lo + 32'd4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bmp_loader_chmask_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : bmp_loader_chmask_if
//  Description : ROM read / RAM write bus between the BMP loader (master) and
//                the image memories (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface bmp_loader_chmask_if import bmp_pkg::*; #(
  parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  ROM_ren;
  logic [ADDR_WIDTH-1:0] ROM_addr;
  logic [BYTE_WIDTH-1:0] ROM_out;
  logic                  RAM_ren;
  logic                  RAM_wen;
  logic [BYTE_WIDTH-1:0] RAM_in;
  logic [ADDR_WIDTH-1:0] RAM_addr;

  modport master (
    output ROM_ren, ROM_addr, RAM_ren, RAM_wen, RAM_in, RAM_addr,
    input  ROM_out
  );

  modport slave (
    input  ROM_ren, ROM_addr, RAM_ren, RAM_wen, RAM_in, RAM_addr,
    output ROM_out
  );
endinterface
`default_nettype wire

// File: rtl/bmp_hdr_parser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : bmp_hdr_parser
//  Description : Captures width, height and pixel offset from the byte stream
//                being written; optionally flags a bad signature / bpp.
//                Optional feature macro: BMP_HDR_CHECK_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module bmp_hdr_parser import bmp_pkg::*; #(
  parameter int BYTE_WIDTH  = BYTE_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int HDR_FIELD_W = 32
`ifdef BMP_HDR_CHECK_EN
  , parameter int CHANNELS  = 3
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [BYTE_WIDTH-1:0]  wr_data,
  output logic [HDR_FIELD_W-1:0] img_width,
  output logic [HDR_FIELD_W-1:0] img_height,
  output logic [HDR_FIELD_W-1:0] pix_offset,
  output logic                   hdr_bad
);

  logic [HDR_FIELD_W-1:0] r_width;
  logic [HDR_FIELD_W-1:0] r_height;
  logic [HDR_FIELD_W-1:0] r_offset;
  logic [31:0]            w_addr32;

  assign w_addr32 = 32'(wr_addr);

  // Shift header bytes in from the top so the first (LSB) byte ends at bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width  <= '0;
      r_height <= '0;
      r_offset <= '0;
    end else if (start) begin
      r_width  <= '0;
      r_height <= '0;
      r_offset <= '0;
    end else if (wr_en) begin
      if (field_hit(w_addr32, 32'(OFF_LO)))
        r_offset <= {wr_data, r_offset[HDR_FIELD_W-1:BYTE_WIDTH]};
      if (field_hit(w_addr32, 32'(W_LO)))
        r_width <= {wr_data, r_width[HDR_FIELD_W-1:BYTE_WIDTH]};
      if (field_hit(w_addr32, 32'(H_LO)))
        r_height <= {wr_data, r_height[HDR_FIELD_W-1:BYTE_WIDTH]};
    end
  end

  assign img_width  = r_width;
  assign img_height = r_height;
  assign pix_offset = r_offset;

`ifdef BMP_HDR_CHECK_EN
  localparam logic [15:0] c_bpp = 16'(CHANNELS * 8);

  // Flag the byte currently being written if it breaks signature or bpp
  assign hdr_bad = wr_en && (
      ((wr_addr == ADDR_WIDTH'(SIG0))     && (wr_data != BYTE_WIDTH'(8'h42)))      ||
      ((wr_addr == ADDR_WIDTH'(SIG1))     && (wr_data != BYTE_WIDTH'(8'h4D)))      ||
      ((wr_addr == ADDR_WIDTH'(BPP_LO))   && (wr_data != BYTE_WIDTH'(c_bpp[7:0]))) ||
      ((wr_addr == ADDR_WIDTH'(BPP_LO+1)) && (wr_data != BYTE_WIDTH'(c_bpp[15:8]))));
`else
  assign hdr_bad = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/bmp_loader_chmask.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : bmp_loader_chmask
//  Description : Copies a BMP image from ROM to RAM at one byte per cycle,
//                exposing header fields and zeroing selected B/G/R channels
//                in the pixel region. Optional header check: BMP_HDR_CHECK_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module bmp_loader_chmask import bmp_pkg::*; #(
  parameter int BYTE_WIDTH  = BYTE_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int TOTAL_SIZE  = 786486,
  parameter int CHANNELS    = 3,
  parameter int HDR_FIELD_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [CHANNELS-1:0]    ch_mask,
  bmp_loader_chmask_if.master    bus,
  output logic [HDR_FIELD_W-1:0] img_width,
  output logic [HDR_FIELD_W-1:0] img_height,
  output logic [HDR_FIELD_W-1:0] pix_offset,
  output logic                   error,
  output logic                   done
);

  localparam int                    c_cnt_w    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_last     = ADDR_WIDTH'(TOTAL_SIZE - 1);
  // pix_offset is only trustworthy once all four of its bytes are in
  localparam logic [ADDR_WIDTH-1:0] c_pix_min  = ADDR_WIDTH'(OFF_LO + 4);
  localparam logic [c_cnt_w-1:0]    c_ch_last  = c_cnt_w'(CHANNELS - 1);

  state_t                r_state;
  logic                  r_rom_ren;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [CHANNELS-1:0]   r_mask;
  logic [c_cnt_w-1:0]    r_ch_cnt;
  logic                  r_done;
  logic                  r_error;

  logic                  w_start;
  logic                  w_hdr_bad;
  logic                  w_pix;
  logic                  w_zero;

  assign w_start = (r_state == ST_IDLE) && in_valid;
  assign w_pix   = r_wen && (r_wr_addr >= c_pix_min) &&
                   (HDR_FIELD_W'(r_wr_addr) >= pix_offset);
  assign w_zero  = w_pix && r_mask[r_ch_cnt];

  bmp_hdr_parser #(
    .BYTE_WIDTH  (BYTE_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .HDR_FIELD_W (HDR_FIELD_W)
`ifdef BMP_HDR_CHECK_EN
    , .CHANNELS  (CHANNELS)
`endif
  ) u_hdr (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (w_start),
    .wr_en      (r_wen),
    .wr_addr    (r_wr_addr),
    .wr_data    (bus.ROM_out),
    .img_width  (img_width),
    .img_height (img_height),
    .pix_offset (pix_offset),
    .hdr_bad    (w_hdr_bad)
  );

  // Control FSM: issues ROM reads and sequences drain / done / error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rom_ren  <= 1'b0;
      r_rom_addr <= '0;
      r_mask     <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_state    <= ST_COPY;
            r_mask     <= ch_mask;
            r_rom_ren  <= 1'b1;
            r_rom_addr <= '0;
          end
        end
        ST_COPY: begin
          if (w_hdr_bad) begin
            r_error   <= 1'b1;
            r_rom_ren <= 1'b0;
            r_state   <= ST_DRAIN;
          end else if (r_rom_addr == c_last) begin
            r_rom_ren <= 1'b0;
            r_state   <= ST_DRAIN;
          end else begin
            r_rom_addr <= r_rom_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_hdr_bad)
            r_error <= 1'b1;
          // Wait until the final in-flight write has left the pipeline
          if (!r_wen) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!in_valid) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write pipeline trails reads by one cycle; channel counter walks pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen     <= 1'b0;
      r_wr_addr <= '0;
      r_ch_cnt  <= '0;
    end else begin
      r_wen     <= r_rom_ren;
      r_wr_addr <= r_rom_addr;
      if (w_start)
        r_ch_cnt <= '0;
      else if (w_pix)
        r_ch_cnt <= (r_ch_cnt == c_ch_last) ? '0 : r_ch_cnt + 1'b1;
    end
  end

  assign bus.ROM_ren  = r_rom_ren;
  assign bus.ROM_addr = r_rom_addr;
  assign bus.RAM_ren  = 1'b0;
  assign bus.RAM_wen  = r_wen;
  assign bus.RAM_addr = r_wr_addr;
  assign bus.RAM_in   = (r_wen && !w_zero) ? bus.ROM_out : '0;
  assign done         = r_done;
  assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bmp_loader_chmask.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bmp_loader_chmask
//  Description : Scoreboard bench for bmp_loader_chmask on a small random
//                BGR24 image; a reference model predicts every RAM write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bmp_loader_chmask;
  import bmp_pkg::*;

  localparam int BW    = 8;
  localparam int AW    = 20;
  localparam int TOTAL = 150;   // 54-byte header + 32 pixels * 3 bytes
  localparam int CH    = 3;
  localparam int FW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [CH-1:0] ch_mask = '0;
  logic [FW-1:0] img_width, img_height, pix_offset;
  logic          error, done;

  bmp_loader_chmask_if #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  bmp_loader_chmask #(
    .BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .TOTAL_SIZE(TOTAL),
    .CHANNELS(CH), .HDR_FIELD_W(FW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .ch_mask    (ch_mask),
    .bus        (bus),
    .img_width  (img_width),
    .img_height (img_height),
    .pix_offset (pix_offset),
    .error      (error),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Image ROM with one cycle of read latency
  logic [7:0] rom [TOTAL];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.ROM_out <= '0;
    else if (bus.ROM_ren) bus.ROM_out <= rom[int'(bus.ROM_addr)];
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cur_w, cur_h;
  int  lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Random image of w x (32/w) pixels with a well-formed BITMAPINFOHEADER
  task automatic build_image(input int w);
    int h;
    h = 32 / w;
    cur_w = w;
    cur_h = h;
    for (int i = 0; i < HDR_SIZE; i++) rom[i] = 8'h00;
    rom[0] = 8'h42;
    rom[1] = 8'h4D;
    for (int i = 0; i < 4; i++) begin
      rom[2 + i]  = 8'((TOTAL    >> (8 * i)) & 255);
      rom[6 + i]  = 8'($urandom);
      rom[10 + i] = 8'((HDR_SIZE >> (8 * i)) & 255);
      rom[18 + i] = 8'((w        >> (8 * i)) & 255);
      rom[22 + i] = 8'((h        >> (8 * i)) & 255);
    end
    rom[14] = 8'd40;
    rom[26] = 8'd1;
    rom[28] = 8'd24;
    for (int i = HDR_SIZE; i < TOTAL; i++) rom[i] = 8'($urandom);
  endtask

  // Reference: header verbatim, pixel byte zeroed if its channel is masked
  task automatic push_expected(input logic [CH-1:0] mask, input int limit);
    int off;
    logic [7:0] b;
    off = {rom[13], rom[12], rom[11], rom[10]};
    for (int a = 0; a < limit; a++) begin
      b = rom[a];
      if (a >= off && mask[(a - off) % CH]) b = 8'h00;
      exp_q.push_back('{addr: AW'(a), data: b});
    end
  endtask

  // Monitor: every RAM write must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.RAM_wen) begin
      chk("ram_ren", bus.RAM_ren, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h with no write expected",
                 bus.RAM_addr, bus.RAM_in);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", bus.RAM_addr, mon_e.addr);
        chk("wr_data", bus.RAM_in, mon_e.data);
      end
    end
  end

  task automatic chk_all_zero();
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rom_ren", bus.ROM_ren, 0);
    chk("rst_rom_addr", bus.ROM_addr, 0);
    chk("rst_ram_ren", bus.RAM_ren, 0);
    chk("rst_ram_wen", bus.RAM_wen, 0);
    chk("rst_ram_addr", bus.RAM_addr, 0);
    chk("rst_ram_in", bus.RAM_in, 0);
    chk("rst_width", img_width, 0);
    chk("rst_height", img_height, 0);
    chk("rst_offset", pix_offset, 0);
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic kick(input logic [CH-1:0] mask, input int limit);
    push_expected(mask, limit);
    @(negedge clk);
    ch_mask  = mask;
    in_valid = 1'b1;
  endtask

  // Count cycles from the sampling edge until done rises (bounded)
  task automatic wait_done(input bit drop, output int n_out);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    @(posedge clk);
    while (n < TOTAL + 40 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 5) ch_mask = CH'($urandom);
      if (drop && n == 10) in_valid = 1'b0;
      if (done) seen = 1'b1;
    end
    n_out = seen ? n : 0;
  endtask

  task automatic post_done(input bit hold);
    chk("writes_left", exp_q.size(), 0);
    chk("img_width", img_width, cur_w);
    chk("img_height", img_height, cur_h);
    chk("pix_offset", pix_offset, HDR_SIZE);
    chk("error_clear", error, 0);
    if (hold) begin
      repeat (3) begin
        @(posedge clk);
        #1 chk("done_hold", done, 1);
      end
    end else begin
      @(posedge clk);
      #1 chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CH-1:0] m;
    int first;

    build_image(8);
    repeat (3) @(negedge clk);
    chk_all_zero();
    rst_n = 1'b1;

    // Plain copy, in_valid held high
    kick(3'b000, TOTAL);
    wait_done(1'b0, lat);
    chk("latency_plain", lat, TOTAL + 2);
    post_done(1'b1);

    // Green and red zeroed
    go_idle();
    kick(3'b110, TOTAL);
    wait_done(1'b0, lat);
    chk("latency_gr", lat, TOTAL + 2);
    post_done(1'b1);

    // Reset mid-copy, then a full copy afterwards
    go_idle();
    build_image(4);
    kick(3'b010, TOTAL);
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero();
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    kick(CH'($urandom), TOTAL);
    wait_done(1'b0, lat);
    chk("latency_after_rst", lat, TOTAL + 2);
    post_done(1'b1);

    // in_valid dropped early: copy completes, done lasts one cycle
    go_idle();
    kick(3'b011, TOTAL);
    wait_done(1'b1, lat);
    chk("latency_drop", lat, TOTAL + 2);
    post_done(1'b0);

    // Restart zeroing only blue
    go_idle();
    kick(3'b001, TOTAL);
    wait_done(1'b0, lat);
    chk("latency_blue", lat, TOTAL + 2);
    post_done(1'b1);

    // Random images and masks
    for (int r = 0; r < 3; r++) begin
      go_idle();
      build_image(($urandom_range(0, 1) == 0) ? 4 : 8);
      m = CH'($urandom);
      kick(m, TOTAL);
      wait_done(r == 1, lat);
      chk("latency_rand", lat, TOTAL + 2);
      post_done(r != 1);
    end

    // Bad signature byte
    go_idle();
    build_image(8);
    rom[0] = 8'h41;
`ifdef BMP_HDR_CHECK_EN
    kick(3'b000, 2);
    first = 0;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (n >= 2) begin
        chk("err_flag", error, 1);
        chk("err_rom_ren", bus.ROM_ren, 0);
      end
      if (done && first == 0) first = n;
    end
    chk("err_done_at", first, 4);
    chk("err_writes_left", exp_q.size(), 0);
    go_idle();
    chk("err_cleared", error, 0);
`else
    kick(3'b000, TOTAL);
    wait_done(1'b0, lat);
    chk("latency_badsig", lat, TOTAL + 2);
    chk("badsig_no_error", error, 0);
    chk("badsig_writes_left", exp_q.size(), 0);
    first = 0;
`endif

    go_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
